// File: rtl/deser_pkg.sv
// +--------------------------------------------------------------------------+
// | deser_pkg : shared types and constants for serial_deserializer            |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

package deser_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

   localparam logic DIR_MSB_FIRST = 1'b1;
   localparam logic DIR_LSB_FIRST = 1'b0;

endpackage

`default_nettype wire

// File: rtl/sipo_shifter.sv
// +--------------------------------------------------------------------------+
// | sipo_shifter : n-bit serial-in shift register, clear/shift/direction      |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module sipo_shifter
   import deser_pkg::*;
#(
   parameter int n = 4
) (
   input  logic         Clock,
   input  logic         Reset,
   input  logic         Clear_i,
   input  logic         Shift_i,
   input  logic         Dir_i,
   input  logic         SerialIn_i,
   output logic [n-1:0] Data_o
);

   logic [n-1:0] sr_q;
   logic [n-1:0] sr_d;

   always_comb begin
      sr_d = sr_q;
      if (Clear_i) begin
         sr_d = '0;
      end else if (Shift_i) begin
         if (Dir_i == DIR_MSB_FIRST) sr_d = {sr_q[n-2:0], SerialIn_i};
         else                        sr_d = {SerialIn_i, sr_q[n-1:1]};
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) sr_q <= '0;
      else        sr_q <= sr_d;
   end

   assign Data_o = sr_q;

endmodule

`default_nettype wire

// File: rtl/serial_deserializer.sv
// +--------------------------------------------------------------------------+
// | serial_deserializer : framed serial-to-parallel receiver, Valid/Ready out |
// | Option: DESER_PARITY_CHECK_EN (trailing even-parity bit per frame)        |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module serial_deserializer
   import deser_pkg::*;
#(
   parameter int n = 4
) (
   input  logic         Clock,
   input  logic         Reset,
   input  logic         Start,
   input  logic         Enable,
   input  logic         SerialIn,
   input  logic         Direction,
   input  logic         Ready,
   output logic [n-1:0] Result,
   output logic         Valid,
   output logic         Busy,
   output logic         Overrun,
   output logic         ParityErr
);

`ifdef DESER_PARITY_CHECK_EN
   localparam int FRAME_LEN = n + 1;
   localparam int CW        = $clog2(n + 2);
`else
   localparam int FRAME_LEN = n;
   localparam int CW        = $clog2(n + 1);
`endif
   localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

   state_e          state_q,  state_d;
   logic            dir_q,    dir_d;
   logic [CW-1:0]   count_q,  count_d;
   logic [n-1:0]    result_q, result_d;
   logic            valid_q,  valid_d;
   logic            over_q,   over_d;
   logic            perr_q,   perr_d;

   logic            sr_clr;
   logic            sr_shift;
   logic            word_rdy;
   logic [n-1:0]    sr_data;
   logic [n-1:0]    word;
   logic            word_perr;

   sipo_shifter #(.n(n)) u_shifter (
      .Clock      (Clock),
      .Reset      (Reset),
      .Clear_i    (sr_clr),
      .Shift_i    (sr_shift),
      .Dir_i      (dir_q),
      .SerialIn_i (SerialIn),
      .Data_o     (sr_data)
   );

   // The completing bit is still on SerialIn, so the word is assembled
   // combinationally to offer it on the same edge that samples it.
`ifdef DESER_PARITY_CHECK_EN
   assign word      = sr_data;
   assign word_perr = (^sr_data) ^ SerialIn;
`else
   assign word      = (dir_q == DIR_MSB_FIRST) ? {sr_data[n-2:0], SerialIn}
                                               : {SerialIn, sr_data[n-1:1]};
   assign word_perr = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      dir_d    = dir_q;
      count_d  = count_q;
      sr_clr   = 1'b0;
      sr_shift = 1'b0;
      word_rdy = 1'b0;
      if (Start) begin
         state_d = SHIFT;
         dir_d   = Direction;
         count_d = '0;
         sr_clr  = 1'b1;
      end else if (state_q == SHIFT && Enable) begin
         count_d = count_q + CW'(1);
`ifdef DESER_PARITY_CHECK_EN
         sr_shift = (count_q < CW'(n));
`else
         sr_shift = 1'b1;
`endif
         if (count_q == LAST_IDX) begin
            word_rdy = 1'b1;
            state_d  = IDLE;
            count_d  = '0;
         end
      end
   end

   always_comb begin
      result_d = result_q;
      perr_d   = perr_q;
      valid_d  = valid_q;
      over_d   = over_q;
      if (valid_q && Ready) valid_d = 1'b0;
      if (word_rdy) begin
         if (!valid_q || Ready) begin
            result_d = word;
            perr_d   = word_perr;
            valid_d  = 1'b1;
         end else begin
            over_d   = 1'b1;
         end
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q  <= IDLE;
         dir_q    <= DIR_LSB_FIRST;
         count_q  <= '0;
         result_q <= '0;
         valid_q  <= 1'b0;
         over_q   <= 1'b0;
         perr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         dir_q    <= dir_d;
         count_q  <= count_d;
         result_q <= result_d;
         valid_q  <= valid_d;
         over_q   <= over_d;
         perr_q   <= perr_d;
      end
   end

   assign Result    = result_q;
   assign Valid     = valid_q;
   assign Busy      = (state_q == SHIFT);
   assign Overrun   = over_q;
   assign ParityErr = perr_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_deserializer.sv
// +--------------------------------------------------------------------------+
// | tb_serial_deserializer : table, directed and random checks vs bit model   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_serial_deserializer;

   localparam int N = 4;
`ifdef DESER_PARITY_CHECK_EN
   localparam int FRAME = N + 1;
`else
   localparam int FRAME = N;
`endif

   logic         Clock, Reset, Start, Enable, SerialIn, Direction, Ready;
   logic [N-1:0] Result;
   logic         Valid, Busy, Overrun, ParityErr;

   int n_total = 0;
   int n_pass  = 0;

   serial_deserializer #(.n(N)) dut (
      .Clock     (Clock),
      .Reset     (Reset),
      .Start     (Start),
      .Enable    (Enable),
      .SerialIn  (SerialIn),
      .Direction (Direction),
      .Ready     (Ready),
      .Result    (Result),
      .Valid     (Valid),
      .Busy      (Busy),
      .Overrun   (Overrun),
      .ParityErr (ParityErr)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Reference model: collects frame bits in a list and builds the word by
   // bit position once the frame length is reached.
   bit           m_active;
   bit           m_dir;
   bit           bits[$];
   logic [N-1:0] m_result;
   logic         m_valid, m_over, m_perr;

   task automatic model_reset();
      m_active = 0; m_dir = 0; bits.delete();
      m_result = '0; m_valid = 0; m_over = 0; m_perr = 0;
   endtask

   task automatic model_edge(input bit s, input bit e, input bit b, input bit d, input bit r);
      bit           wr;
      logic [N-1:0] w;
      bit           p;
      wr = 0; w = '0; p = 0;
      if (s) begin
         bits.delete(); m_active = 1; m_dir = d;
      end else if (m_active && e) begin
         bits.push_back(b);
         if (bits.size() == FRAME) begin
            for (int i = 0; i < N; i++) begin
               if (m_dir) w[N-1-i] = bits[i];
               else       w[i]     = bits[i];
            end
`ifdef DESER_PARITY_CHECK_EN
            for (int i = 0; i < FRAME; i++) p = p ^ bits[i];
`endif
            wr = 1; m_active = 0; bits.delete();
         end
      end
      if (m_valid && r) m_valid = 0;
      if (wr) begin
         if (!m_valid) begin
            m_result = w; m_perr = p; m_valid = 1;
         end else begin
            m_over = 1;
         end
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic check_model(input string tag);
      check({tag, ".Result"},    32'(Result),    32'(m_result));
      check({tag, ".Valid"},     32'(Valid),     32'(m_valid));
      check({tag, ".Busy"},      32'(Busy),      32'(m_active));
      check({tag, ".Overrun"},   32'(Overrun),   32'(m_over));
      check({tag, ".ParityErr"}, 32'(ParityErr), 32'(m_perr));
   endtask

   // Drive one cycle of inputs, advance one edge, compare against the model.
   task automatic cyc(input bit s, input bit e, input bit b, input bit d, input bit r, input string tag);
      Start = s; Enable = e; SerialIn = b; Direction = d; Ready = r;
      model_edge(s, e, b, d, r);
      @(posedge Clock); #1;
      check_model(tag);
   endtask

   task automatic frame(input bit d, input bit r, input logic [7:0] seq, input int len, input string tag);
      cyc(1, 0, 0, d, r, tag);
      for (int i = len - 1; i >= 0; i--) cyc(0, 1, seq[i], ~d, r, tag);
   endtask

   typedef struct {
      bit           s, e, b, d, r;
      logic [N-1:0] x_result;
      bit           x_valid, x_busy;
   } vec_t;

   initial begin
      vec_t tbl[12];

      Start = 0; Enable = 0; SerialIn = 0; Direction = 0; Ready = 0;
      Reset = 0;
      model_reset();
      @(posedge Clock); #1;
      check_model("reset");
      Reset = 1;

`ifndef DESER_PARITY_CHECK_EN
      tbl[0]  = '{1,0,0,1,0, 4'h0, 0, 1};
      tbl[1]  = '{0,1,1,0,0, 4'h0, 0, 1};
      tbl[2]  = '{0,1,0,0,0, 4'h0, 0, 1};
      tbl[3]  = '{0,1,1,0,0, 4'h0, 0, 1};
      tbl[4]  = '{0,1,1,0,0, 4'hB, 1, 0};
      tbl[5]  = '{0,0,0,0,1, 4'hB, 0, 0};
      tbl[6]  = '{1,1,1,0,1, 4'hB, 0, 1};
      tbl[7]  = '{0,1,1,1,1, 4'hB, 0, 1};
      tbl[8]  = '{0,1,0,1,1, 4'hB, 0, 1};
      tbl[9]  = '{0,1,1,1,1, 4'hB, 0, 1};
      tbl[10] = '{0,1,1,1,1, 4'hD, 1, 0};
      tbl[11] = '{0,0,0,0,1, 4'hD, 0, 0};
      for (int i = 0; i < 12; i++) begin
         cyc(tbl[i].s, tbl[i].e, tbl[i].b, tbl[i].d, tbl[i].r, $sformatf("tbl%0d", i));
         check($sformatf("tbl%0d.Result", i), 32'(Result), 32'(tbl[i].x_result));
         check($sformatf("tbl%0d.Valid", i),  32'(Valid),  32'(tbl[i].x_valid));
         check($sformatf("tbl%0d.Busy", i),   32'(Busy),   32'(tbl[i].x_busy));
      end

      frame(1, 0, 8'b0110, 4, "ovr1");
      check("ovr_first", 32'(Result), 32'h6);
      frame(1, 0, 8'b1001, 4, "ovr2");
      check("ovr_keep",   32'(Result),  32'h6);
      check("ovr_flag",   32'(Overrun), 32'h1);
      cyc(0, 0, 0, 0, 1, "ovr_drain");
      check("ovr_drain_valid", 32'(Valid),   32'h0);
      check("ovr_sticky",      32'(Overrun), 32'h1);

      cyc(1, 0, 0, 1, 0, "abort");
      cyc(0, 1, 1, 1, 0, "abort");
      cyc(0, 1, 1, 1, 0, "abort");
      frame(1, 0, 8'b0011, 4, "abort2");
      check("abort_result", 32'(Result), 32'h3);
      cyc(0, 0, 0, 0, 1, "abort_drain");
`else
      frame(1, 1, 8'b10111, 5, "par_ok");
      check("par_ok_result", 32'(Result),    32'hB);
      check("par_ok_err",    32'(ParityErr), 32'h0);
      cyc(0, 0, 0, 0, 1, "par_drain");
      frame(1, 1, 8'b10110, 5, "par_bad");
      check("par_bad_result", 32'(Result),    32'hB);
      check("par_bad_err",    32'(ParityErr), 32'h1);
      cyc(0, 0, 0, 0, 1, "par_drain2");
`endif

      cyc(1, 0, 0, 1, 1, "rst_mid");
      for (int i = 0; i < 3; i++) cyc(0, 1, 1, 1, 1, "rst_mid");
      #2 Reset = 0; model_reset(); #1;
      check_model("async_reset");
      check("async_reset_result", 32'(Result), 32'h0);
      @(posedge Clock); #1 Reset = 1;
`ifdef DESER_PARITY_CHECK_EN
      frame(1, 0, 8'b11110, 5, "after_rst");
`else
      frame(1, 0, 8'b1111, 4, "after_rst");
`endif
      check("after_rst_result", 32'(Result), 32'hF);

      for (int i = 0; i < 400; i++) begin
         cyc(($urandom_range(0, 15) == 0), ($urandom_range(0, 9) < 7), 1'($urandom),
             1'($urandom), ($urandom_range(0, 3) != 0), "rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
